// File: rtl/pps_phase_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : pps_phase_ctrl_if
//  Purpose  : Signal bundle between the GPS / local 1PPS sources, the phase
//             controller and the divider's compensation inputs.
//  Ports    : _1PPS_GPS, _1PPS_Local           -> controller inputs
//             Phase_Compensate_Type/_Compensate -> divider correction
//             Comp_Active, Phase_Err, Err_Valid,
//             Locked, GPS_Lost                  -> status
//  Revision : 1.0  initial release
// ============================================================================
interface pps_phase_ctrl_if;
  logic        _1PPS_GPS;
  logic        _1PPS_Local;
  logic        Phase_Compensate_Type;  // 0 = lengthen, 1 = shorten
  logic [23:0] Phase_Compensate;       // unsigned correction in cycles
  logic        Comp_Active;
  logic [24:0] Phase_Err;              // two's complement, + = local lags GPS
  logic        Err_Valid;
  logic        Locked;
  logic        GPS_Lost;

  // master: the phase controller
  modport master (
    input  _1PPS_GPS, _1PPS_Local,
    output Phase_Compensate_Type, Phase_Compensate, Comp_Active,
           Phase_Err, Err_Valid, Locked, GPS_Lost
  );

  // slave: pulse sources and correction / status consumers
  modport slave (
    output _1PPS_GPS, _1PPS_Local,
    input  Phase_Compensate_Type, Phase_Compensate, Comp_Active,
           Phase_Err, Err_Valid, Locked, GPS_Lost
  );
endinterface
`default_nettype wire

// File: rtl/pps_phase_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : pps_phase_ctrl
//  Purpose  : Closed-loop phase controller for the 1PPS divider. Measures the
//             GPS-to-local 1PPS offset in CLK_Sys cycles, issues a bounded
//             period correction for one local period per second and reports
//             lock / GPS-loss status.
//  Ports    : CLK_Sys  - system clock (sole clock)
//             CLK_Rst  - asynchronous active-high reset
//             bus      - pps_phase_ctrl_if.master (1PPS inputs, correction
//                        outputs, status)
//  Revision : 1.0  initial release
// ============================================================================
module pps_phase_ctrl #(
  parameter int P        = 10_000_000,
  parameter int MAX_STEP = 1000,
  parameter int DEADBAND = 1,
  parameter int LOCK_CNT = 4
) (
  input  logic                   CLK_Sys,
  input  logic                   CLK_Rst,
  pps_phase_ctrl_if.master       bus
);

  localparam logic [24:0] c_P        = 25'(P);
  localparam logic [24:0] c_HALF     = 25'(P / 2);
  localparam logic [24:0] c_PC_MAX   = 25'(2 * P - 1);
  localparam logic [24:0] c_MAX_STEP = 25'(MAX_STEP);
  localparam logic [24:0] c_DEADBAND = 25'(DEADBAND);
  localparam int          c_LCW      = $clog2(LOCK_CNT + 1);
  localparam logic [c_LCW-1:0] c_LOCK_CNT = c_LCW'(LOCK_CNT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TRACK = 2'd1,
    S_APPLY = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        gps_sync_q, loc_sync_q;
  logic              g_edge_q, l_edge_q;
  logic [24:0]       pc_q, pc_d;
  logic [24:0]       err_q, err_d;
  logic              valid_q, valid_d;
  logic [23:0]       mag_q, mag_d;
  logic              type_q, type_d;
  logic              active_q, active_d;
  logic [c_LCW-1:0]  lcnt_q, lcnt_d;
  logic              lost_q, lost_d;

  logic [24:0]       w_v;
  logic              w_lags;
  logic [24:0]       w_err;
  logic [24:0]       w_abs;
  logic              w_in_db;
  logic [23:0]       w_mag;
  logic              w_pc_sat;

  // Both inputs share the same 2-FF + edge-register path so their edge
  // pulses carry identical latency and the measured offset has no bias.
  always_ff @(posedge CLK_Sys or posedge CLK_Rst) begin
    if (CLK_Rst) begin
      gps_sync_q <= '0;
      loc_sync_q <= '0;
      g_edge_q   <= 1'b0;
      l_edge_q   <= 1'b0;
    end else begin
      gps_sync_q <= {gps_sync_q[1:0], bus._1PPS_GPS};
      loc_sync_q <= {loc_sync_q[1:0], bus._1PPS_Local};
      g_edge_q   <= gps_sync_q[1] & ~gps_sync_q[2];
      l_edge_q   <= loc_sync_q[1] & ~loc_sync_q[2];
    end
  end

  // pc_q holds the phase of the current cycle relative to the last GPS
  // edge; the g_edge cycle itself is phase 0, so the following cycle is 1.
  assign w_pc_sat = (pc_q == c_PC_MAX);
  assign pc_d     = g_edge_q ? 25'd1 : (w_pc_sat ? pc_q : pc_q + 25'd1);

  // Measurement datapath
  assign w_v     = g_edge_q ? '0 : pc_q;
  assign w_lags  = (w_v < c_HALF);
  assign w_err   = w_lags ? w_v : (w_v - c_P);
  assign w_abs   = w_err[24] ? (~w_err + 25'd1) : w_err;
  assign w_in_db = (w_abs <= c_DEADBAND);
  assign w_mag   = w_in_db ? '0 :
                   (w_abs > c_MAX_STEP) ? c_MAX_STEP[23:0] : w_abs[23:0];

  always_ff @(posedge CLK_Sys or posedge CLK_Rst) begin
    if (CLK_Rst) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      err_q    <= '0;
      valid_q  <= 1'b0;
      mag_q    <= '0;
      type_q   <= 1'b0;
      active_q <= 1'b0;
      lcnt_q   <= '0;
      lost_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      err_q    <= err_d;
      valid_q  <= valid_d;
      mag_q    <= mag_d;
      type_q   <= type_d;
      active_q <= active_d;
      lcnt_q   <= lcnt_d;
      lost_q   <= lost_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    valid_d  = 1'b0;
    mag_d    = mag_q;
    type_d   = type_q;
    active_d = active_q;
    lcnt_d   = lcnt_q;
    lost_d   = lost_q;

    if (g_edge_q) lost_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (g_edge_q) state_d = S_TRACK;
      end
      S_TRACK, S_APPLY: begin
        // Saturation without a fresh GPS edge means the reference is gone;
        // this wins over a coincident local edge.
        if (w_pc_sat && !g_edge_q) begin
          state_d  = S_IDLE;
          lost_d   = 1'b1;
          lcnt_d   = '0;
          mag_d    = '0;
          active_d = 1'b0;
        end else if (l_edge_q) begin
          // Each local edge both ends the running correction and loads
          // the next one, giving exactly one adjusted period.
          err_d    = w_err;
          valid_d  = 1'b1;
          mag_d    = w_mag;
          type_d   = w_lags;
          active_d = (w_mag != '0);
          if (!w_in_db)
            lcnt_d = '0;
          else if (lcnt_q != c_LOCK_CNT)
            lcnt_d = lcnt_q + c_LCW'(1);
          state_d  = (w_mag != '0) ? S_APPLY : S_TRACK;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.Phase_Err             = err_q;
  assign bus.Err_Valid             = valid_q;
  assign bus.Phase_Compensate      = mag_q;
  assign bus.Phase_Compensate_Type = type_q;
  assign bus.Comp_Active           = active_q;
  assign bus.Locked                = (lcnt_q == c_LOCK_CNT);
  assign bus.GPS_Lost              = lost_q;

endmodule
`default_nettype wire

// File: tb/tb_pps_phase_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_pps_phase_ctrl
//  Purpose  : Directed self-checking bench for pps_phase_ctrl with P = 1000,
//             MAX_STEP = 50, DEADBAND = 1, LOCK_CNT = 4. Each "window" is one
//             1000-cycle second in which GPS and local pulses are placed at
//             chosen cycle offsets.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pps_phase_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pps_phase_ctrl_if bus ();

  pps_phase_ctrl #(
    .P        (1000),
    .MAX_STEP (50),
    .DEADBAND (1),
    .LOCK_CNT (4)
  ) dut (
    .CLK_Sys (clk),
    .CLK_Rst (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Capture of the outputs at every Err_Valid strobe
  int          ev_cnt  = 0;
  int          act_cnt = 0;
  logic [24:0] mon_err    = '0;
  logic [23:0] mon_mag    = '0;
  logic        mon_type   = 1'b0;
  logic        mon_locked = 1'b0;

  always @(negedge clk) begin
    if (bus.Err_Valid === 1'b1) begin
      ev_cnt     <= ev_cnt + 1;
      mon_err    <= bus.Phase_Err;
      mon_mag    <= bus.Phase_Compensate;
      mon_type   <= bus.Phase_Compensate_Type;
      mon_locked <= bus.Locked;
    end
    if (bus.Comp_Active === 1'b1) act_cnt <= act_cnt + 1;
  end

  logic pr0_lost, pr1_lost, pr0_locked, pr1_locked;

  task automatic do_reset();
    rst = 1'b1;
    bus._1PPS_GPS   = 1'b0;
    bus._1PPS_Local = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
  endtask

  // One 1000-cycle second; offsets < 0 suppress that pulse. Outputs are
  // snapshotted at cycle probe_at and probe_at+1.
  task automatic window(input int g_at, input int l_at, input int probe_at);
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (c == probe_at) begin
        pr0_lost = bus.GPS_Lost; pr0_locked = bus.Locked;
      end
      if (c == probe_at + 1) begin
        pr1_lost = bus.GPS_Lost; pr1_locked = bus.Locked;
      end
      bus._1PPS_GPS   = (g_at >= 0) && (c >= g_at) && (c < g_at + 10);
      bus._1PPS_Local = (l_at >= 0) && (c >= l_at) && (c < l_at + 10);
    end
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (bus.Phase_Err !== 25'd0) begin n_bad++; $display("FAIL reset_err: got %0d expected 0", bus.Phase_Err); end
    n_vec++; if (bus.Err_Valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", bus.Err_Valid); end
    n_vec++; if (bus.Phase_Compensate !== 24'd0) begin n_bad++; $display("FAIL reset_mag: got %0d expected 0", bus.Phase_Compensate); end
    n_vec++; if (bus.Phase_Compensate_Type !== 1'b0) begin n_bad++; $display("FAIL reset_type: got %b expected 0", bus.Phase_Compensate_Type); end
    n_vec++; if (bus.Comp_Active !== 1'b0) begin n_bad++; $display("FAIL reset_active: got %b expected 0", bus.Comp_Active); end
    n_vec++; if (bus.Locked !== 1'b0) begin n_bad++; $display("FAIL reset_locked: got %b expected 0", bus.Locked); end
    n_vec++; if (bus.GPS_Lost !== 1'b0) begin n_bad++; $display("FAIL reset_lost: got %b expected 0", bus.GPS_Lost); end
  endtask

  task automatic test_late20();
    int ev0, act0;
    do_reset();
    ev0 = ev_cnt; act0 = act_cnt;
    window(100, 120, -1);
    n_vec++; if (ev_cnt - ev0 !== 1) begin n_bad++; $display("FAIL late20_evcnt: got %0d expected 1", ev_cnt - ev0); end
    n_vec++; if (mon_err !== 25'd20) begin n_bad++; $display("FAIL late20_err: got %0d expected 20", $signed(mon_err)); end
    n_vec++; if (mon_type !== 1'b1) begin n_bad++; $display("FAIL late20_type: got %b expected 1", mon_type); end
    n_vec++; if (mon_mag !== 24'd20) begin n_bad++; $display("FAIL late20_mag: got %0d expected 20", mon_mag); end
    n_vec++; if (bus.Comp_Active !== 1'b1) begin n_bad++; $display("FAIL late20_active: got %b expected 1", bus.Comp_Active); end
    // Next second offset 1: inside deadband, correction withdrawn.
    window(119, 120, -1);
    n_vec++; if (mon_err !== 25'd1) begin n_bad++; $display("FAIL late20_err2: got %0d expected 1", $signed(mon_err)); end
    n_vec++; if (mon_mag !== 24'd0) begin n_bad++; $display("FAIL late20_mag2: got %0d expected 0", mon_mag); end
    n_vec++; if (bus.Comp_Active !== 1'b0) begin n_bad++; $display("FAIL late20_active2: got %b expected 0", bus.Comp_Active); end
    n_vec++; if (act_cnt - act0 !== 1000) begin n_bad++; $display("FAIL late20_active_len: got %0d expected 1000", act_cnt - act0); end
  endtask

  task automatic test_early30();
    int ev0;
    logic [24:0] exp_err;
    exp_err = -25'sd30;
    do_reset();
    ev0 = ev_cnt;
    window(30, -1, -1);
    window(30, 0, -1);
    n_vec++; if (ev_cnt - ev0 !== 1) begin n_bad++; $display("FAIL early30_evcnt: got %0d expected 1", ev_cnt - ev0); end
    n_vec++; if (mon_err !== exp_err) begin n_bad++; $display("FAIL early30_err: got %0d expected -30", $signed(mon_err)); end
    n_vec++; if (mon_type !== 1'b0) begin n_bad++; $display("FAIL early30_type: got %b expected 0", mon_type); end
    n_vec++; if (mon_mag !== 24'd30) begin n_bad++; $display("FAIL early30_mag: got %0d expected 30", mon_mag); end
  endtask

  task automatic test_clamp();
    do_reset();
    window(100, 300, -1);
    n_vec++; if (mon_err !== 25'd200) begin n_bad++; $display("FAIL clamp_err: got %0d expected 200", $signed(mon_err)); end
    n_vec++; if (mon_mag !== 24'd50) begin n_bad++; $display("FAIL clamp_mag: got %0d expected 50", mon_mag); end
    n_vec++; if (bus.Comp_Active !== 1'b1) begin n_bad++; $display("FAIL clamp_active: got %b expected 1", bus.Comp_Active); end
  endtask

  task automatic test_lock();
    int ev0;
    do_reset();
    ev0 = ev_cnt;
    window(100, 101, -1);
    n_vec++; if (mon_err !== 25'd1) begin n_bad++; $display("FAIL lock_err1: got %0d expected 1", $signed(mon_err)); end
    n_vec++; if (mon_mag !== 24'd0) begin n_bad++; $display("FAIL lock_mag1: got %0d expected 0", mon_mag); end
    window(100, 100, -1);
    n_vec++; if (mon_err !== 25'd0) begin n_bad++; $display("FAIL lock_err2: got %0d expected 0", $signed(mon_err)); end
    window(100, 101, -1);
    n_vec++; if (mon_locked !== 1'b0) begin n_bad++; $display("FAIL lock_3rd: got %b expected 0", mon_locked); end
    window(100, 100, -1);
    n_vec++; if (mon_locked !== 1'b1) begin n_bad++; $display("FAIL lock_4th: got %b expected 1", mon_locked); end
    n_vec++; if (mon_mag !== 24'd0) begin n_bad++; $display("FAIL lock_mag4: got %0d expected 0", mon_mag); end
    n_vec++; if (ev_cnt - ev0 !== 4) begin n_bad++; $display("FAIL lock_evcnt: got %0d expected 4", ev_cnt - ev0); end
    window(100, 105, -1);
    n_vec++; if (mon_err !== 25'd5) begin n_bad++; $display("FAIL lock_err5: got %0d expected 5", $signed(mon_err)); end
    n_vec++; if (mon_mag !== 24'd5) begin n_bad++; $display("FAIL lock_mag5: got %0d expected 5", mon_mag); end
    n_vec++; if (mon_locked !== 1'b0) begin n_bad++; $display("FAIL lock_drop: got %b expected 0", mon_locked); end
  endtask

  task automatic test_gps_loss();
    int ev0;
    do_reset();
    for (int i = 0; i < 5; i++) window(100, 100, -1);
    n_vec++; if (bus.Locked !== 1'b1) begin n_bad++; $display("FAIL loss_prelock: got %b expected 1", bus.Locked); end
    ev0 = ev_cnt;
    window(-1, -1, -1);
    // Last GPS raw edge at cycle 100 of the 5th second; pc hits 1999 so
    // GPS_Lost shows 2003 cycles later, at cycle 103 of this window.
    window(-1, 150, 102);
    n_vec++; if (pr0_lost !== 1'b0) begin n_bad++; $display("FAIL loss_early: got %b expected 0", pr0_lost); end
    n_vec++; if (pr1_lost !== 1'b1) begin n_bad++; $display("FAIL loss_rise: got %b expected 1", pr1_lost); end
    n_vec++; if (pr0_locked !== 1'b1) begin n_bad++; $display("FAIL loss_locked_before: got %b expected 1", pr0_locked); end
    n_vec++; if (pr1_locked !== 1'b0) begin n_bad++; $display("FAIL loss_locked_after: got %b expected 0", pr1_locked); end
    n_vec++; if (bus.Phase_Compensate !== 24'd0) begin n_bad++; $display("FAIL loss_mag: got %0d expected 0", bus.Phase_Compensate); end
    n_vec++; if (bus.Comp_Active !== 1'b0) begin n_bad++; $display("FAIL loss_active: got %b expected 0", bus.Comp_Active); end
    n_vec++; if (ev_cnt - ev0 !== 0) begin n_bad++; $display("FAIL loss_no_valid: got %0d expected 0", ev_cnt - ev0); end
    window(100, -1, 103);
    n_vec++; if (pr0_lost !== 1'b1) begin n_bad++; $display("FAIL loss_hold: got %b expected 1", pr0_lost); end
    n_vec++; if (pr1_lost !== 1'b0) begin n_bad++; $display("FAIL loss_clear: got %b expected 0", pr1_lost); end
  endtask

  task automatic test_simul_reset();
    int ev0;
    do_reset();
    window(100, 100, -1);
    n_vec++; if (mon_err !== 25'd0) begin n_bad++; $display("FAIL simul_err: got %0d expected 0", $signed(mon_err)); end
    n_vec++; if (mon_type !== 1'b1) begin n_bad++; $display("FAIL simul_type: got %b expected 1", mon_type); end
    window(100, 120, -1);
    n_vec++; if (bus.Phase_Compensate !== 24'd20) begin n_bad++; $display("FAIL apply_mag: got %0d expected 20", bus.Phase_Compensate); end
    // Reset between clock edges must clear everything at once.
    repeat (50) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_vec++; if (bus.Phase_Compensate !== 24'd0) begin n_bad++; $display("FAIL arst_mag: got %0d expected 0", bus.Phase_Compensate); end
    n_vec++; if (bus.Comp_Active !== 1'b0) begin n_bad++; $display("FAIL arst_active: got %b expected 0", bus.Comp_Active); end
    n_vec++; if (bus.Phase_Err !== 25'd0) begin n_bad++; $display("FAIL arst_err: got %0d expected 0", bus.Phase_Err); end
    n_vec++; if (bus.Phase_Compensate_Type !== 1'b0) begin n_bad++; $display("FAIL arst_type: got %b expected 0", bus.Phase_Compensate_Type); end
    @(negedge clk);
    rst = 1'b0;
    ev0 = ev_cnt;
    // Back in IDLE: a lone local edge is ignored.
    window(-1, 100, -1);
    n_vec++; if (ev_cnt - ev0 !== 0) begin n_bad++; $display("FAIL arst_idle: got %0d expected 0", ev_cnt - ev0); end
  endtask

  initial begin
    bus._1PPS_GPS   = 1'b0;
    bus._1PPS_Local = 1'b0;
    pr0_lost = 1'b0; pr1_lost = 1'b0; pr0_locked = 1'b0; pr1_locked = 1'b0;
    test_reset();
    test_late20();
    test_early30();
    test_clamp();
    test_lock();
    test_gps_loss();
    test_simul_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
